// File: rtl/sys_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sys_bus_arbiter_pkg
// Shared types and constants for the system-memory port arbiter.
//   arb_state_t  : arbiter FSM states
//   GRANT_I_BIT  : index of the I-cache bit in the one-hot grant vector
//   GRANT_D_BIT  : index of the D-cache bit in the one-hot grant vector
//   PREAD/PWRITE : encoding of the rw direction signals
// ---------------------------------------------------------------------------
package sys_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam int GRANT_I_BIT = 0;
    localparam int GRANT_D_BIT = 1;

    localparam logic PREAD  = 1'b0;
    localparam logic PWRITE = 1'b1;

endpackage

// File: rtl/sys_bus_arbiter_beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
// Counts completed bus beats within one read transaction.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to 0 (takes priority over inc)
//   inc      : advance the count by one; wraps to 0 after BURSTLEN-1
//   tc       : terminal count, high while count == BURSTLEN-1
// ---------------------------------------------------------------------------
module beat_counter #(
    parameter int BURSTLEN = 4,
    parameter int CNTWIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [CNTWIDTH-1:0] LAST_BEAT = CNTWIDTH'(BURSTLEN - 1);

    logic [CNTWIDTH-1:0] count;

    assign tc = (count == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            // Explicit wrap keeps the count inside 0..BURSTLEN-1 even when
            // BURSTLEN is not a power of two.
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sys_bus_arbiter
// Shares the single system-memory port between the I-cache and D-cache
// controllers. One requester owns the port for a whole transaction
// (BURSTLEN-beat read or single-beat write), then priority rotates.
//   clk, rst                       : clock, synchronous active-high reset
//   I_strobe/I_rw/I_addr/I_wdata   : I-cache request side
//   I_ready/I_rdata                : I-cache per-beat response
//   D_*                            : D-cache equivalents
//   SYSstrobe/SYSrw/SYSaddr/SYSdata_out : bus request side
//   SYSdata_in/SYSready            : bus response side
//   grant                          : one-hot owner (bit0 I, bit1 D), also
//                                    the visible form of the FSM state
//
// Handshake: a requester holds x_strobe high (its valid) for the whole
// transaction; a beat transfers on every clock edge where the owner's
// strobe and SYSready are both high, and that beat is reported to the
// owner combinationally on x_ready in the same cycle.
// ---------------------------------------------------------------------------
module sys_bus_arbiter
    import sys_bus_arbiter_pkg::*;
#(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int BURSTLEN  = 4,
    parameter int CNTWIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 I_strobe,
    input  logic                 I_rw,
    input  logic [ADDRWIDTH-1:0] I_addr,
    input  logic [DATAWIDTH-1:0] I_wdata,
    output logic                 I_ready,
    output logic [DATAWIDTH-1:0] I_rdata,
    input  logic                 D_strobe,
    input  logic                 D_rw,
    input  logic [ADDRWIDTH-1:0] D_addr,
    input  logic [DATAWIDTH-1:0] D_wdata,
    output logic                 D_ready,
    output logic [DATAWIDTH-1:0] D_rdata,
    output logic                 SYSstrobe,
    output logic                 SYSrw,
    output logic [ADDRWIDTH-1:0] SYSaddr,
    output logic [DATAWIDTH-1:0] SYSdata_out,
    input  logic [DATAWIDTH-1:0] SYSdata_in,
    input  logic                 SYSready,
    output logic [1:0]           grant
);

    arb_state_t state, state_d;
    logic       lrw, lrw_d;
    logic       last, last_d;   // 1: D was served last
    logic       beat_clr, beat_inc, beat_tc;
    logic       own_strobe;

    beat_counter #(
        .BURSTLEN (BURSTLEN),
        .CNTWIDTH (CNTWIDTH)
    ) u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (beat_clr),
        .inc   (beat_inc),
        .tc    (beat_tc)
    );

    // Strobe of whoever currently owns the port (don't-care in IDLE).
    assign own_strobe = (state == GRANT_D) ? D_strobe : I_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lrw   <= PREAD;
            last  <= 1'b1;
        end else begin
            state <= state_d;
            lrw   <= lrw_d;
            last  <= last_d;
        end
    end

    always_comb begin
        state_d  = state;
        lrw_d    = lrw;
        last_d   = last;
        beat_clr = 1'b0;
        beat_inc = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (I_strobe && (!D_strobe || last)) begin
                    state_d  = GRANT_I;
                    lrw_d    = I_rw;
                    beat_clr = 1'b1;
                end else if (D_strobe) begin
                    state_d  = GRANT_D;
                    lrw_d    = D_rw;
                    beat_clr = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                // A final beat completes even if the strobe drops with it.
                if (SYSready && (lrw == PWRITE || beat_tc)) begin
                    state_d  = IDLE;
                    last_d   = (state == GRANT_D);
                    beat_clr = 1'b1;
                end else if (!own_strobe) begin
                    state_d  = IDLE;
                    beat_clr = 1'b1;
                end else if (SYSready) begin
                    beat_inc = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                beat_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        SYSstrobe   = 1'b0;
        SYSrw       = 1'b0;
        SYSaddr     = '0;
        SYSdata_out = '0;
        I_ready     = 1'b0;
        D_ready     = 1'b0;
        I_rdata     = '0;
        D_rdata     = '0;
        grant       = 2'b00;
        unique case (state)
            GRANT_I: begin
                SYSstrobe          = I_strobe;
                SYSrw              = lrw;
                SYSaddr            = I_addr;
                SYSdata_out        = I_wdata;
                I_ready            = SYSready;
                I_rdata            = SYSdata_in;
                D_rdata            = SYSdata_in;
                grant[GRANT_I_BIT] = 1'b1;
            end
            GRANT_D: begin
                SYSstrobe          = D_strobe;
                SYSrw              = lrw;
                SYSaddr            = D_addr;
                SYSdata_out        = D_wdata;
                D_ready            = SYSready;
                I_rdata            = SYSdata_in;
                D_rdata            = SYSdata_in;
                grant[GRANT_D_BIT] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int CW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          I_strobe, I_rw, I_ready;
    logic [AW-1:0] I_addr;
    logic [DW-1:0] I_wdata, I_rdata;
    logic          D_strobe, D_rw, D_ready;
    logic [AW-1:0] D_addr;
    logic [DW-1:0] D_wdata, D_rdata;
    logic          SYSstrobe, SYSrw, SYSready;
    logic [AW-1:0] SYSaddr;
    logic [DW-1:0] SYSdata_out, SYSdata_in;
    logic [1:0]    grant;

    sys_bus_arbiter #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .BURSTLEN  (BL),
        .CNTWIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .I_strobe    (I_strobe),
        .I_rw        (I_rw),
        .I_addr      (I_addr),
        .I_wdata     (I_wdata),
        .I_ready     (I_ready),
        .I_rdata     (I_rdata),
        .D_strobe    (D_strobe),
        .D_rw        (D_rw),
        .D_addr      (D_addr),
        .D_wdata     (D_wdata),
        .D_ready     (D_ready),
        .D_rdata     (D_rdata),
        .SYSstrobe   (SYSstrobe),
        .SYSrw       (SYSrw),
        .SYSaddr     (SYSaddr),
        .SYSdata_out (SYSdata_out),
        .SYSdata_in  (SYSdata_in),
        .SYSready    (SYSready),
        .grant       (grant)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Owner: 0 none, 1 I-cache, 2 D-cache. m_left counts beats still owed.
    int m_owner  = 0;
    int m_left   = 0;
    bit m_write  = 1'b0;
    bit m_last_d = 1'b1;

    always @(negedge clk) begin
        logic          e_stb, e_rw, e_ir, e_dr, own;
        logic [1:0]    e_g;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd, e_rd;
        e_stb = 1'b0; e_rw = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_g = 2'b00; e_a = '0; e_wd = '0; e_rd = '0;
        if (m_owner == 1) begin
            e_g = 2'b01; e_stb = I_strobe; e_rw = m_write; e_a = I_addr;
            e_wd = I_wdata; e_ir = SYSready; e_rd = SYSdata_in;
        end else if (m_owner == 2) begin
            e_g = 2'b10; e_stb = D_strobe; e_rw = m_write; e_a = D_addr;
            e_wd = D_wdata; e_dr = SYSready; e_rd = SYSdata_in;
        end
        if (chk_on) begin
            chk("m_grant", grant, e_g);
            chk("m_SYSstrobe", SYSstrobe, e_stb);
            chk("m_SYSrw", SYSrw, e_rw);
            chk("m_SYSaddr", SYSaddr, e_a);
            chk("m_SYSdata_out", SYSdata_out, e_wd);
            chk("m_I_ready", I_ready, e_ir);
            chk("m_D_ready", D_ready, e_dr);
            chk("m_I_rdata", I_rdata, e_rd);
            chk("m_D_rdata", D_rdata, e_rd);
        end
        // Advance the model to what holds after the coming edge.
        if (rst) begin
            m_owner = 0; m_left = 0; m_write = 1'b0; m_last_d = 1'b1;
        end else if (m_owner == 0) begin
            if (I_strobe && (!D_strobe || m_last_d)) begin
                m_owner = 1; m_write = I_rw; m_left = I_rw ? 1 : BL;
            end else if (D_strobe) begin
                m_owner = 2; m_write = D_rw; m_left = D_rw ? 1 : BL;
            end
        end else begin
            own = (m_owner == 1) ? I_strobe : D_strobe;
            if (SYSready && m_left == 1) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0;
            end else if (!own) begin
                m_owner = 0;
            end else if (SYSready) begin
                m_left = m_left - 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with the winner's strobe already up; returns
    // in the IDLE cycle that follows the final beat.
    task automatic txn(input logic [1:0] g, input int n, input logic rw,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        tick();
        chk("txn_grant", grant, g);
        chk("txn_SYSstrobe", SYSstrobe, 1'b1);
        chk("txn_SYSrw", SYSrw, rw);
        chk("txn_SYSaddr", SYSaddr, addr);
        chk("txn_SYSdata_out", SYSdata_out, wd);
        for (int b = 0; b < n; b++) begin
            SYSready = 1'b1;
            #1;
            chk("txn_held_grant", grant, g);
            chk("txn_I_ready", I_ready, g[0]);
            chk("txn_D_ready", D_ready, g[1]);
            tick();
        end
        SYSready = 1'b0;
        #1;
        chk("txn_release", grant, 2'b00);
        chk("txn_release_stb", SYSstrobe, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        I_strobe = 0; I_rw = 0; I_addr = '0; I_wdata = '0;
        D_strobe = 0; D_rw = 0; D_addr = '0; D_wdata = '0;
        SYSready = 0; SYSdata_in = 32'h0000_abcd;
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_SYSstrobe", SYSstrobe, 1'b0);
        chk("reset_I_rdata", I_rdata, 0);

        // Single I read; grant must not appear in the request cycle.
        I_strobe = 1; I_rw = 0; I_addr = 32'h100;
        #1;
        chk("no_comb_grant", grant, 2'b00);
        txn(2'b01, 4, 1'b0, 32'h100, 32'h0);
        I_strobe = 0;
        tick();

        // Single D write.
        D_strobe = 1; D_rw = 1; D_addr = 32'h2004; D_wdata = 32'hdeadbeef;
        txn(2'b10, 1, 1'b1, 32'h2004, 32'hdeadbeef);
        D_strobe = 0;
        tick();

        // Simultaneous requests after reset: I, gap, D, gap, I.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        I_strobe = 1; I_rw = 0; I_addr = 32'h300; I_wdata = 32'h0;
        D_strobe = 1; D_rw = 1; D_addr = 32'h400; D_wdata = 32'h55;
        txn(2'b01, 4, 1'b0, 32'h300, 32'h0);
        txn(2'b10, 1, 1'b1, 32'h400, 32'h55);
        txn(2'b01, 4, 1'b0, 32'h300, 32'h0);
        I_strobe = 0; D_strobe = 0;
        tick();

        // Stray SYSready in IDLE must not shorten the next read.
        SYSready = 1;
        tick();
        tick();
        SYSready = 0;
        I_strobe = 1; I_rw = 0; I_addr = 32'h600;
        txn(2'b01, 4, 1'b0, 32'h600, 32'h0);
        I_strobe = 0;
        tick();

        // Reset after 2 of 4 beats; next read needs all 4.
        I_strobe = 1;
        tick();
        SYSready = 1;
        tick();
        tick();
        SYSready = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_abort_stb", SYSstrobe, 1'b0);
        chk("rst_abort_grant", grant, 2'b00);
        txn(2'b01, 4, 1'b0, 32'h600, 32'h0);
        I_strobe = 0;
        tick();

        // D aborts after one beat; last stays I so D wins the next tie.
        D_strobe = 1; D_rw = 0; D_addr = 32'h500;
        tick();
        chk("abort_grant", grant, 2'b10);
        SYSready = 1;
        tick();
        SYSready = 0;
        D_strobe = 0;
        tick();
        chk("abort_idle", grant, 2'b00);
        I_strobe = 1; D_strobe = 1;
        tick();
        chk("tie_after_abort", grant, 2'b10);
        I_strobe = 0; D_strobe = 0;
        tick();
        tick();

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if (!I_strobe) begin
                if ($urandom_range(0, 2) == 0) begin
                    I_strobe = 1; I_rw = 1'($urandom_range(0, 1));
                    I_addr = $urandom; I_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                I_strobe = 0;
            end
            if (!D_strobe) begin
                if ($urandom_range(0, 2) == 0) begin
                    D_strobe = 1; D_rw = 1'($urandom_range(0, 1));
                    D_addr = $urandom; D_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                D_strobe = 0;
            end
            SYSready   = 1'($urandom_range(0, 1));
            SYSdata_in = $urandom;
        end
        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
